// File: rtl/nios2_system_led_fader_pkg.sv
// Shared constants and helpers for the LED fader: level width, LMAX, counter widths.
`timescale 1ns/1ps
package nios2_system_led_fader_pkg;

  localparam int DEF_DUTY_W   = 4;
  localparam int DEF_PWM_DIV  = 64;
  localparam int DEF_RAMP_DIV = 4;

  typedef logic [DEF_DUTY_W-1:0] level_t;

  localparam level_t LMAX = '1;

  function automatic int lmax_of(input int w);
    return (1 << w) - 1;
  endfunction

  // Counter width for a modulus of n; a modulus of 1 still needs one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/nios2_system_led_fader_chan.sv
// One LED channel: brightness level that ramps or snaps toward its target,
// a registered PWM compare against the shared count, and a level/target mismatch flag.
`timescale 1ns/1ps
module nios2_system_led_fader_chan
  import nios2_system_led_fader_pkg::*;
#(
  parameter int DUTY_W = DEF_DUTY_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_led,
  input  logic              i_fade_en,
  input  logic              i_ramp_step,
  input  logic              i_period_end,
  input  logic [DUTY_W-1:0] i_pwm_cnt,
  output logic              o_pwm,
  output logic              o_mismatch
);

  localparam logic [DUTY_W-1:0] LMAX_V = '1;

  logic [DUTY_W-1:0] r_level;
  logic [DUTY_W-1:0] w_target;
  logic              r_pwm;

  assign w_target = i_led ? LMAX_V : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_level <= '0;
      r_pwm   <= 1'b0;
    end else begin
      // fade_en is sampled at the boundary itself, so a toggle mid-ramp waits for the next one
      if (i_fade_en) begin
        if (i_ramp_step) begin
          if (r_level < w_target) begin
            r_level <= r_level + DUTY_W'(1);
          end else if (r_level > w_target) begin
            r_level <= r_level - DUTY_W'(1);
          end
        end
      end else if (i_period_end) begin
        r_level <= w_target;
      end
      r_pwm <= (i_pwm_cnt < r_level);
    end
  end

  assign o_pwm      = r_pwm;
  assign o_mismatch = (r_level != w_target);

endmodule

// File: rtl/nios2_system_led_fader.sv
// LED fader top: shared prescaler, PWM count and ramp count driving NUM_LEDS channels;
// busy is the registered OR of all channel mismatches.
`timescale 1ns/1ps
module nios2_system_led_fader
  import nios2_system_led_fader_pkg::*;
#(
  parameter int NUM_LEDS = 8,
  parameter int DUTY_W   = DEF_DUTY_W,
  parameter int PWM_DIV  = DEF_PWM_DIV,
  parameter int RAMP_DIV = DEF_RAMP_DIV
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NUM_LEDS-1:0] led_in,
  input  logic                fade_en,
  output logic [NUM_LEDS-1:0] led_out,
  output logic                busy
);

  localparam int PRESC_W = cnt_w(PWM_DIV);
  localparam int RAMP_W  = cnt_w(RAMP_DIV);

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(PWM_DIV - 1);
  localparam logic [DUTY_W-1:0]  PWM_LAST   = DUTY_W'(lmax_of(DUTY_W) - 1);
  localparam logic [RAMP_W-1:0]  RAMP_LAST  = RAMP_W'(RAMP_DIV - 1);

  logic [PRESC_W-1:0]  r_presc;
  logic [DUTY_W-1:0]   r_pwm_cnt;
  logic [RAMP_W-1:0]   r_ramp_cnt;
  logic                r_busy;
  logic                w_pwm_tick;
  logic                w_period_end;
  logic                w_ramp_step;
  logic [NUM_LEDS-1:0] w_mismatch;

  assign w_pwm_tick   = (r_presc == PRESC_LAST);
  assign w_period_end = w_pwm_tick && (r_pwm_cnt == PWM_LAST);
  assign w_ramp_step  = w_period_end && (r_ramp_cnt == RAMP_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_presc    <= '0;
      r_pwm_cnt  <= '0;
      r_ramp_cnt <= '0;
      r_busy     <= 1'b0;
    end else begin
      r_presc <= w_pwm_tick ? '0 : r_presc + PRESC_W'(1);
      if (w_pwm_tick) begin
        r_pwm_cnt <= (r_pwm_cnt == PWM_LAST) ? '0 : r_pwm_cnt + DUTY_W'(1);
      end
      if (w_period_end) begin
        r_ramp_cnt <= (r_ramp_cnt == RAMP_LAST) ? '0 : r_ramp_cnt + RAMP_W'(1);
      end
      r_busy <= |w_mismatch;
    end
  end

  for (genvar gi = 0; gi < NUM_LEDS; gi++) begin : g_chan
    nios2_system_led_fader_chan #(
      .DUTY_W(DUTY_W)
    ) u_chan (
      .clk          (clk),
      .reset_n      (reset_n),
      .i_led        (led_in[gi]),
      .i_fade_en    (fade_en),
      .i_ramp_step  (w_ramp_step),
      .i_period_end (w_period_end),
      .i_pwm_cnt    (r_pwm_cnt),
      .o_pwm        (led_out[gi]),
      .o_mismatch   (w_mismatch[gi])
    );
  end

  assign busy = r_busy;

endmodule
